complex_multiplier_rs: RTL
==========================

// Module: complex_multiplier_rs
// PURPOSE
//  Parallel pipelined complex multiplier (data x twiddle) for the FFT stages, with per-path
//  round-half-up rescaling, saturation to a programmable output width, conjugate-twiddle
//  mode (IFFT), valid pipelining and a sticky saturation-event counter. Sits between a
//  butterfly stage and the next butterfly; drops in where the full-width product was used.
// PARAMETERS
//  NUM_PARALLEL_PATHS  16  independent complex lanes processed per clock
//  DATA_IN_WIDTH       13  signed data input width (re and im)
//  TW_WIDTH            9   signed twiddle width (re and im)
//  TW_FRAC_BITS        7   twiddle fractional bits = arithmetic right-shift applied to result
//  DATA_OUT_WIDTH      13  signed output width after round + saturate
//  CNT_WIDTH           16  width of saturation-event counter
// PORTS
//  clk        in   1                      clock, all logic posedge
//  rstn       in   1                      asynchronous active-low reset
//  in_valid   in   1                      input vector valid this cycle
//  conj_en    in   1                      1: multiply by conj(tw); sampled with in_valid
//  din_re     in   [DATA_IN_WIDTH] x N    data real, signed
//  din_im     in   [DATA_IN_WIDTH] x N    data imag, signed
//  tw_re      in   [TW_WIDTH] x N         twiddle real, signed
//  tw_im      in   [TW_WIDTH] x N         twiddle imag, signed
//  cnt_clr    in   1                      synchronous clear of sat_cnt
//  out_valid  out  1                      output vector valid
//  dout_re    out  [DATA_OUT_WIDTH] x N   result real, signed
//  dout_im    out  [DATA_OUT_WIDTH] x N   result imag, signed
//  sat_flag   out  [N]                    bit i: lane i re or im saturated in this output
//  sat_cnt    out  [CNT_WIDTH]            count of output vectors with any saturation
// BEHAVIOUR
//  - Reset (rstn low, async): all pipeline regs, valid bits, dout_*, sat_flag, sat_cnt -> 0.
//    Reset mid-operation discards all in-flight vectors; no out_valid after release until
//    fresh in_valid has propagated.
//  - Latency fixed 3 cycles: in_valid at edge k -> out_valid high after edge k+3. Full
//    throughput, one vector per clock, no back-pressure. Bubbles preserved exactly.
//  - S1: ac=re*twr, bd=im*twi, ad=re*twi, bc=im*twr, each DATA_IN_WIDTH+TW_WIDTH signed.
//    conj_en registered alongside.
//  - S2: conj_en=0: P_re=ac-bd, P_im=ad+bc; conj_en=1: P_re=ac+bd, P_im=bc-ad.
//    Width DATA_IN_WIDTH+TW_WIDTH+1 (no overflow possible).
//  - S3: R = (P + 2^(TW_FRAC_BITS-1)) >>> TW_FRAC_BITS, computed one bit wider than P
//    (round half toward +inf). Saturate R to [-2^(DOUT-1), 2^(DOUT-1)-1]; sat_flag[i] =
//    re or im of lane i clipped. If TW_FRAC_BITS=0 no rounding add is performed.
//  - Stage regs load only when that stage's valid is 1; otherwise hold (dout_* hold last
//    value while out_valid=0). sat_flag is forced 0 whenever out_valid=0.
//  - sat_cnt: +1 on each cycle with out_valid=1 and |sat_flag; saturates at all-ones (no
//    wrap). cnt_clr=1 -> 0 next edge; clear has priority over simultaneous increment.
//  - conj_en, cnt_clr need no stability outside their sampling cycle.
// TESTING
//  1. din=100+j50, tw=128+j0, conj_en=0 -> 3 cycles later dout=100+j50, sat_flag=0.
//  2. Rounding: din=1+j(-1), tw=64+j0 -> dout=1+j0 (64+64>>7=1; -64+64>>7=0).
//  3. Conj: din=0+j100, tw=0+j128: conj_en=0 -> dout=-100+j0; conj_en=1 -> dout=100+j0.
//  4. Saturation: din=4095+j4095, tw=255+j255, conj_en=0 -> dout_re=0, dout_im=4095,
//     sat_flag[i]=1, sat_cnt increments by 1; hold cnt_clr with a sat vector -> sat_cnt=0.
//  5. Valid pattern 1,0,1,1 with distinct data per lane -> out_valid 1,0,1,1 after 3
//     cycles, lanes independent, dout held during the bubble.
//  6. Drop rstn for 1 cycle with 2 vectors in flight -> out_valid, dout_*, sat_cnt 0
//     immediately; no stale out_valid afterwards; counter saturation check with CNT_WIDTH=4.

Source files
------------

// File: rtl/complex_multiplier_rs.sv
// Pipelined complex multiplier for FFT stages. Each lane is a 3-stage pipe:
// partial products, add/sub (optionally conjugating the twiddle), then round + saturate.

module cmul_lane #(
    parameter int DATA_IN_WIDTH  = 13,
    parameter int TW_WIDTH       = 9,
    parameter int TW_FRAC_BITS   = 7,
    parameter int DATA_OUT_WIDTH = 13
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             s1_en,
    input  logic                             s2_en,
    input  logic                             s3_en,
    input  logic                             conj,
    input  logic signed [DATA_IN_WIDTH-1:0]  din_re,
    input  logic signed [DATA_IN_WIDTH-1:0]  din_im,
    input  logic signed [TW_WIDTH-1:0]       tw_re,
    input  logic signed [TW_WIDTH-1:0]       tw_im,
    output logic signed [DATA_OUT_WIDTH-1:0] dout_re,
    output logic signed [DATA_OUT_WIDTH-1:0] dout_im,
    output logic                             sat
);
    localparam int PW = DATA_IN_WIDTH + TW_WIDTH;
    localparam int SW = PW + 1;
    localparam int RW = SW + 1;
    // Half-LSB rounding constant; evaluates to 0 when there are no fractional bits.
    localparam logic signed [RW-1:0] RND  = RW'((2 ** TW_FRAC_BITS) / 2);
    localparam logic signed [RW-1:0] MAXV = RW'((2 ** (DATA_OUT_WIDTH - 1)) - 1);
    localparam logic signed [RW-1:0] MINV = ~MAXV;

    logic signed [PW-1:0] ac, bd, ad, bc;
    logic signed [SW-1:0] p_re, p_im;
    logic [DATA_OUT_WIDTH:0] re_sat, im_sat;

    // Returns {clipped, value}.
    function automatic logic [DATA_OUT_WIDTH:0] rnd_sat(input logic signed [SW-1:0] p);
        logic signed [RW-1:0] r;
        r = (RW'(p) + RND) >>> TW_FRAC_BITS;
        if (r > MAXV)
            rnd_sat = {1'b1, MAXV[DATA_OUT_WIDTH-1:0]};
        else if (r < MINV)
            rnd_sat = {1'b1, MINV[DATA_OUT_WIDTH-1:0]};
        else
            rnd_sat = {1'b0, r[DATA_OUT_WIDTH-1:0]};
    endfunction

    always_comb begin
        re_sat = rnd_sat(p_re);
        im_sat = rnd_sat(p_im);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ac      <= '0;
            bd      <= '0;
            ad      <= '0;
            bc      <= '0;
            p_re    <= '0;
            p_im    <= '0;
            dout_re <= '0;
            dout_im <= '0;
            sat     <= 1'b0;
        end else begin
            if (s1_en) begin
                ac <= PW'(din_re) * PW'(tw_re);
                bd <= PW'(din_im) * PW'(tw_im);
                ad <= PW'(din_re) * PW'(tw_im);
                bc <= PW'(din_im) * PW'(tw_re);
            end
            if (s2_en) begin
                p_re <= conj ? SW'(ac) + SW'(bd) : SW'(ac) - SW'(bd);
                p_im <= conj ? SW'(bc) - SW'(ad) : SW'(ad) + SW'(bc);
            end
            if (s3_en) begin
                dout_re <= re_sat[DATA_OUT_WIDTH-1:0];
                dout_im <= im_sat[DATA_OUT_WIDTH-1:0];
            end
            // Flag only accompanies a valid output; zero during bubbles.
            sat <= s3_en & (re_sat[DATA_OUT_WIDTH] | im_sat[DATA_OUT_WIDTH]);
        end
    end
endmodule

module complex_multiplier_rs #(
    parameter int NUM_PARALLEL_PATHS = 16,
    parameter int DATA_IN_WIDTH      = 13,
    parameter int TW_WIDTH           = 9,
    parameter int TW_FRAC_BITS       = 7,
    parameter int DATA_OUT_WIDTH     = 13,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                                                clk,
    input  logic                                                rstn,
    input  logic                                                in_valid,
    input  logic                                                conj_en,
    input  logic [NUM_PARALLEL_PATHS-1:0][DATA_IN_WIDTH-1:0]    din_re,
    input  logic [NUM_PARALLEL_PATHS-1:0][DATA_IN_WIDTH-1:0]    din_im,
    input  logic [NUM_PARALLEL_PATHS-1:0][TW_WIDTH-1:0]         tw_re,
    input  logic [NUM_PARALLEL_PATHS-1:0][TW_WIDTH-1:0]         tw_im,
    input  logic                                                cnt_clr,
    output logic                                                out_valid,
    output logic [NUM_PARALLEL_PATHS-1:0][DATA_OUT_WIDTH-1:0]   dout_re,
    output logic [NUM_PARALLEL_PATHS-1:0][DATA_OUT_WIDTH-1:0]   dout_im,
    output logic [NUM_PARALLEL_PATHS-1:0]                       sat_flag,
    output logic [CNT_WIDTH-1:0]                                sat_cnt
);
    localparam int STAGES = 3;

    // vld_pipe[k] marks valid data sitting in stage k+1 registers.
    logic [STAGES-1:0] vld_pipe;
    logic              conj_s1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe <= '0;
            conj_s1  <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-2:0], in_valid};
            if (in_valid)
                conj_s1 <= conj_en;
        end
    end

    assign out_valid = vld_pipe[STAGES-1];

    for (genvar i = 0; i < NUM_PARALLEL_PATHS; i++) begin : g_lane
        cmul_lane #(
            .DATA_IN_WIDTH  (DATA_IN_WIDTH),
            .TW_WIDTH       (TW_WIDTH),
            .TW_FRAC_BITS   (TW_FRAC_BITS),
            .DATA_OUT_WIDTH (DATA_OUT_WIDTH)
        ) u_lane (
            .clk     (clk),
            .rstn    (rstn),
            .s1_en   (in_valid),
            .s2_en   (vld_pipe[0]),
            .s3_en   (vld_pipe[1]),
            .conj    (conj_s1),
            .din_re  (din_re[i]),
            .din_im  (din_im[i]),
            .tw_re   (tw_re[i]),
            .tw_im   (tw_im[i]),
            .dout_re (dout_re[i]),
            .dout_im (dout_im[i]),
            .sat     (sat_flag[i])
        );
    end

    // Sticky event counter: clear wins, otherwise count up and stick at all-ones.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            sat_cnt <= '0;
        else if (cnt_clr)
            sat_cnt <= '0;
        else if (out_valid && (|sat_flag) && (sat_cnt != '1))
            sat_cnt <= sat_cnt + 1'b1;
    end
endmodule
